// File: rtl/tile_collect2d.sv
// Output tile collector: gathers one result pixel per window position into a tile buffer,
// then drains the finished tile downstream in raster order with valid/ready.
module tile_collect2d #(
    parameter int DATA_W   = 8,
    parameter int TILE_W   = 16,
    parameter int TILE_H   = 16,
    parameter int WIN_SIZE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pixel,
    output logic              out_eol,
    output logic              out_last,
    output logic              tile_done,
    output logic [15:0]       tile_count
);

    localparam int OUT_W = TILE_W - WIN_SIZE + 1;
    localparam int OUT_H = TILE_H - WIN_SIZE + 1;
    localparam int XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(OUT_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(OUT_H - 1);

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [XW-1:0]     wr_x_q, wr_x_d, rd_x_q, rd_x_d;
    logic [YW-1:0]     wr_y_q, wr_y_d, rd_y_q, rd_y_d;
    logic [15:0]       tile_count_q, tile_count_d;
    logic [DATA_W-1:0] mem_q [OUT_H][OUT_W];

    logic wr_en, wr_end, rd_xfer, rd_at_last;

    assign wr_en      = in_valid && in_ready;
    assign wr_end     = wr_en && (wr_x_q == X_MAX) && (wr_y_q == Y_MAX);
    assign rd_xfer    = out_valid && out_ready;
    assign rd_at_last = (rd_x_q == X_MAX) && (rd_y_q == Y_MAX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (wr_end) state_d = DRAIN;
            DRAIN:   if (rd_xfer && rd_at_last) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Outputs: everything downstream is gated by out_valid so reset blanks it at once.
    always_comb begin
        in_ready  = (state_q == FILL) && rst_n;
        out_valid = (state_q == DRAIN);
        out_pixel = out_valid ? mem_q[rd_y_q][rd_x_q] : '0;
        out_eol   = out_valid && (rd_x_q == X_MAX);
        out_last  = out_valid && rd_at_last;
        tile_done = rd_xfer && out_last;
    end

    assign tile_count = tile_count_q;

    // Write-side raster position
    always_comb begin
        wr_x_d = wr_x_q;
        wr_y_d = wr_y_q;
        if (wr_en) begin
            if (wr_x_q == X_MAX) begin
                wr_x_d = '0;
                wr_y_d = (wr_y_q == Y_MAX) ? '0 : wr_y_q + 1'b1;
            end else begin
                wr_x_d = wr_x_q + 1'b1;
            end
        end
    end

    // Read-side raster position, advances only on an accepted transfer
    always_comb begin
        rd_x_d = rd_x_q;
        rd_y_d = rd_y_q;
        if (rd_xfer) begin
            if (rd_x_q == X_MAX) begin
                rd_x_d = '0;
                rd_y_d = (rd_y_q == Y_MAX) ? '0 : rd_y_q + 1'b1;
            end else begin
                rd_x_d = rd_x_q + 1'b1;
            end
        end
    end

    assign tile_count_d = tile_done ? tile_count_q + 16'd1 : tile_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_x_q       <= '0;
            wr_y_q       <= '0;
            rd_x_q       <= '0;
            rd_y_q       <= '0;
            tile_count_q <= '0;
        end else begin
            wr_x_q       <= wr_x_d;
            wr_y_q       <= wr_y_d;
            rd_x_q       <= rd_x_d;
            rd_y_q       <= rd_y_d;
            tile_count_q <= tile_count_d;
        end
    end

    // Tile buffer carries no reset; contents are only observed after a full fill.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_y_q][wr_x_q] <= in_pixel;
    end

endmodule

// File: tb/tb_tile_collect2d.sv
// Directed bench for tile_collect2d: default 14x14 output tile plus a 1x1 instance.
module tb_tile_collect2d;

    localparam int NPIX = 196;
    localparam int OW   = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [7:0]  in_pixel = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [7:0]  out_pixel;
    logic        out_eol, out_last, tile_done;
    logic [15:0] tile_count;

    logic        b_in_valid = 1'b0, b_in_ready;
    logic [7:0]  b_in_pixel = '0;
    logic        b_out_valid, b_out_ready = 1'b0;
    logic [7:0]  b_out_pixel;
    logic        b_out_eol, b_out_last, b_tile_done;
    logic [15:0] b_tile_count;

    int n_chk = 0, n_fail = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    tile_collect2d dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_eol(out_eol), .out_last(out_last), .tile_done(tile_done), .tile_count(tile_count)
    );

    tile_collect2d #(.DATA_W(8), .TILE_W(3), .TILE_H(3), .WIN_SIZE(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pixel(b_in_pixel),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pixel(b_out_pixel),
        .out_eol(b_out_eol), .out_last(b_out_last), .tile_done(b_tile_done), .tile_count(b_tile_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic fill_tile(input logic [7:0] base, input bit gaps);
        int i = 0;
        int cyc = 0;
        while (i < NPIX && cyc < 5000) begin
            @(negedge clk);
            in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_pixel = base + 8'(i);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(in_pixel);
                i++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("fill_count", 32'(i), NPIX);
        if (!gaps) chk("fill_cycles", 32'(cyc), NPIX);
        chk("in_ready_drop", 32'(in_ready), 0);
        chk("out_valid_lat1", 32'(out_valid), 1);
    endtask

    task automatic drain_tile(input bit stalls, input bit junk, output int nout);
        int cyc = 0;
        int idx = 0;
        bit done = 0;
        bit held = 0;
        bit ir_seen = 0;
        logic [9:0] hv = '0;
        logic [7:0] e;
        nout = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            out_ready = stalls ? ($urandom_range(0, 9) >= 3) : 1'b1;
            if (junk) begin
                in_valid = 1'b1;
                in_pixel = 8'hAA;
            end
            #1;
            if (in_ready) ir_seen = 1;
            if (held) chk("stall_hold", 32'({out_pixel, out_eol, out_last}), 32'(hv));
            held = out_valid && !out_ready;
            hv   = {out_pixel, out_eol, out_last};
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                chk("pix", 32'(out_pixel), 32'(e));
                chk("eol_last_done", 32'({out_eol, out_last, tile_done}),
                    32'({idx % OW == OW - 1, idx == NPIX - 1, idx == NPIX - 1}));
                idx++;
                nout++;
                if (out_last) done = 1;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("drain_finished", 32'(done), 1);
        chk("in_ready_rearm", 32'(in_ready), 1);
        chk("out_valid_off", 32'(out_valid), 0);
        if (junk) chk("in_ready_in_drain", 32'(ir_seen), 0);
    endtask

    initial begin
        int n;
        logic [7:0] p;

        #1;
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_pixel", 32'(out_pixel), 0);
        chk("reset_flags", 32'({out_eol, out_last, tile_done}), 0);
        chk("reset_tile_count", 32'(tile_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 1);

        // 1: back-to-back tile, index values
        fill_tile(8'h00, 0);
        drain_tile(0, 0, n);
        chk("t1_nout", 32'(n), NPIX);
        chk("t1_tile_count", 32'(tile_count), 1);

        // 2: three tiles with input gaps and output stalls
        reset_dut();
        for (int t = 0; t < 3; t++) begin
            fill_tile(8'(8'h35 * (t + 1)), 1);
            drain_tile(1, 0, n);
            chk("t2_nout", 32'(n), NPIX);
        end
        chk("t2_tile_count", 32'(tile_count), 3);
        chk("t2_queue_empty", 32'(exp_q.size()), 0);

        // 3: in_valid held with 0xAA throughout drain, next tile must be clean
        fill_tile(8'h10, 0);
        drain_tile(0, 1, n);
        fill_tile(8'h80, 0);
        drain_tile(0, 0, n);
        chk("t3_tile_count", 32'(tile_count), 5);

        // 4: reset after 100 inputs, then a full tile
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pixel = 8'hF0 ^ 8'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("t4_in_ready_rst", 32'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_tile(8'h03, 0);
        drain_tile(0, 0, n);
        chk("t4_nout", 32'(n), NPIX);
        chk("t4_tile_count", 32'(tile_count), 1);

        // 5: reset while stalled on the first end-of-row pixel
        fill_tile(8'h40, 0);
        for (int i = 0; i < OW - 1; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            p = exp_q.pop_front();
            chk("t5_pix", 32'(out_pixel), 32'(p));
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("t5_stall_pix", 32'(out_pixel), 32'(8'h40 + 8'(OW - 1)));
        chk("t5_stall_eol", 32'({out_valid, out_eol, out_last}), 32'(3'b110));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_valid_async", 32'(out_valid), 0);
        chk("t5_pix_async", 32'(out_pixel), 0);
        chk("t5_flags_async", 32'({out_eol, out_last, tile_done}), 0);
        chk("t5_tile_count", 32'(tile_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_in_ready", 32'(in_ready), 1);
        exp_q.delete();

        // 6: 1x1 output tiles
        reset_dut();
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            b_in_valid  = 1'b1;
            b_in_pixel  = 8'(8'h21 * (t + 1));
            b_out_ready = 1'b1;
            #1;
            chk("t6_in_ready", 32'(b_in_ready), 1);
            chk("t6_idle_valid", 32'(b_out_valid), 0);
            @(negedge clk);
            b_in_valid = 1'b0;
            #1;
            chk("t6_out_valid", 32'(b_out_valid), 1);
            chk("t6_pix", 32'(b_out_pixel), 32'(8'(8'h21 * (t + 1))));
            chk("t6_eol_last_done", 32'({b_out_eol, b_out_last, b_tile_done}), 32'(3'b111));
            @(negedge clk);
            #1;
            chk("t6_rearm", 32'(b_in_ready), 1);
            chk("t6_count", 32'(b_tile_count), 32'(t + 1));
        end
        chk("t6_tile_count", 32'(b_tile_count), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
